// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF)
// and data access (DM). DM has fixed priority, bounded by a streak counter
// so a waiting fetch is served after MAX_DM_STREAK consecutive DM grants.
//
// Handshake: a requester raises x_req (level) with stable fields and holds it
// until x_valid pulses for exactly one cycle; x_stall = x_req & ~x_valid.
// Toward memory, mem_req is held with stable fields until mem_ready is seen
// high on a clock edge; mem_ready is ignored whenever mem_req is low.
module mem_port_arbiter #(
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_width,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_width,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err,
  output logic [2:0]        dbg_state,
  output logic [7:0]        dbg_streak
);

  localparam int STREAK_W = (MAX_DM_STREAK > 0) ? $clog2(MAX_DM_STREAK + 1) : 1;
  localparam int TO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [2:0] WIDTH_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_DM = 3'd2,
    RESP_IF = 3'd3,
    RESP_DM = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                drop_q, drop_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          width_q, width_d;
  logic                we_q, we_d;

  logic busy;
  logic timed_out;
  logic if_go;
  logic streak_full;

  assign busy        = (state_q == BUSY_IF) || (state_q == BUSY_DM);
  assign timed_out   = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT));
  // A flush in the same cycle cancels the fetch request for arbitration.
  assign if_go       = if_req && !if_flush;
  assign streak_full = (streak_q == STREAK_W'(MAX_DM_STREAK));

  // Next-state, grant decision, streak/drop bookkeeping and timeout counting.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    drop_d   = drop_q;
    to_cnt_d = to_cnt_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    width_d  = width_q;
    we_d     = we_q;
    case (state_q)
      IDLE: begin
        if (dm_req && (!if_go || !streak_full)) begin
          state_d  = BUSY_DM;
          addr_d   = dm_addr;
          wdata_d  = dm_wdata;
          width_d  = dm_width;
          we_d     = dm_we;
          to_cnt_d = '0;
          if (!if_req)          streak_d = '0;
          else if (!streak_full) streak_d = streak_q + 1'b1;
        end else if (if_go) begin
          state_d  = BUSY_IF;
          addr_d   = if_addr;
          wdata_d  = '0;
          width_d  = WIDTH_WORD;
          we_d     = 1'b0;
          to_cnt_d = '0;
          streak_d = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (state_q == BUSY_IF && if_flush) drop_d = 1'b1;
        if (timed_out) begin
          // Abort cycle: mem_req drops, bus_err pulses, response carries zero.
          state_d = (state_q == BUSY_IF) ? RESP_IF : RESP_DM;
          rdata_d = '0;
        end else if (mem_ready) begin
          state_d = (state_q == BUSY_IF) ? RESP_IF : RESP_DM;
          rdata_d = mem_rdata;
        end else if (TIMEOUT != 0) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      RESP_IF: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      RESP_DM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      streak_q <= '0;
      drop_q   <= 1'b0;
      to_cnt_q <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      width_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
      to_cnt_q <= to_cnt_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      width_q  <= width_d;
      we_q     <= we_d;
    end
  end

  assign mem_req    = busy && !timed_out;
  assign mem_we     = mem_req && we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_width  = width_q;
  assign bus_err    = busy && timed_out;

  // A flush seen in the response cycle itself also suppresses the pulse.
  assign if_valid   = (state_q == RESP_IF) && !drop_q && !if_flush;
  assign dm_valid   = (state_q == RESP_DM);
  assign if_rdata   = rdata_q;
  assign dm_rdata   = rdata_q;
  assign if_stall   = if_req && !if_valid;
  assign dm_stall   = dm_req && !dm_valid;

  assign dbg_state  = state_q;
  assign dbg_streak = 8'(streak_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (MAX_DM_STREAK=4, TIMEOUT=8).
// Inputs change just after each negedge; outputs are checked 1 ns later.
module tb_mem_port_arbiter;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BUSY_IF = 3'd1;
  localparam logic [2:0] S_BUSY_DM = 3'd2;
  localparam logic [2:0] S_RESP_IF = 3'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_width;
  logic        mem_req, mem_we, mem_ready, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_width;
  logic [2:0]  dbg_state;
  logic [7:0]  dbg_streak;

  int total = 0;
  int bad   = 0;

  // Clock and DUT
  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(32), .MAX_DM_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_width(dm_width), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_width(mem_width), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .bus_err(bus_err),
    .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  // Watchdog: the directed sequence is a few hundred cycles long
  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  // Called from an IDLE slot whose inputs cause a grant at the next edge.
  // delay = BUSY slots with mem_ready low before the completing slot.
  task automatic xact(input bit exp_dm, input logic [31:0] exp_addr,
                      input logic [2:0] exp_width, input bit exp_we,
                      input logic [31:0] exp_wdata, input int exp_streak,
                      input int delay, input logic [31:0] rd);
    nclk(); #1;
    chk("busy_state", 32'(dbg_state), exp_dm ? 32'(S_BUSY_DM) : 32'(S_BUSY_IF));
    chk1("busy_mem_req", mem_req, 1'b1);
    chk("busy_addr", mem_addr, exp_addr);
    chk("busy_width", 32'(mem_width), 32'(exp_width));
    chk1("busy_we", mem_we, exp_we);
    if (exp_we) chk("busy_wdata", mem_wdata, exp_wdata);
    chk("streak", 32'(dbg_streak), 32'(exp_streak));
    for (int i = 0; i < delay; i++) begin
      nclk(); #1;
      chk1("hold_mem_req", mem_req, 1'b1);
      chk("hold_addr", mem_addr, exp_addr);
      chk1("hold_we", mem_we, exp_we);
    end
    mem_ready = 1'b1;
    mem_rdata = rd;
    nclk();
    mem_ready = 1'b0;
    mem_rdata = 32'hA5A5_A5A5;
    #1;
    chk1("resp_dm_valid", dm_valid, exp_dm);
    chk1("resp_if_valid", if_valid, !exp_dm);
    chk1("resp_mem_req", mem_req, 1'b0);
    if (exp_dm) begin
      chk("resp_dm_rdata", dm_rdata, rd);
      chk1("resp_dm_stall", dm_stall, 1'b0);
    end else begin
      chk("resp_if_rdata", if_rdata, rd);
      chk1("resp_if_stall", if_stall, 1'b0);
    end
    nclk(); #1;
    chk("idle_state", 32'(dbg_state), 32'(S_IDLE));
    chk1("idle_dm_valid", dm_valid, 1'b0);
    chk1("idle_if_valid", if_valid, 1'b0);
    chk1("idle_mem_we", mem_we, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_width = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    // Reset state; stall stays combinational even in reset
    repeat (2) nclk();
    if_req = 1'b1;
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_dm_valid", dm_valid, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_streak", 32'(dbg_streak), 32'd0);
    chk1("rst_if_stall", if_stall, 1'b1);
    if_req = 1'b0;
    nclk();
    rst_n = 1'b1;

    // Flush in IDLE masks the fetch request for that cycle
    nclk();
    if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b1;
    nclk();
    if_flush = 1'b0;
    #1;
    chk("mask_state", 32'(dbg_state), 32'(S_IDLE));
    chk1("mask_mem_req", mem_req, 1'b0);

    // 1: IF only, mem_ready one cycle after mem_req
    xact(1'b0, 32'h100, 3'b010, 1'b0, 32'h0, 0, 1, 32'h0000_0013);
    if_req = 1'b0;

    // 2: simultaneous IF and DM load: DM first, then IF resets streak
    nclk();
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_width = 3'b010;
    xact(1'b1, 32'h200, 3'b010, 1'b0, 32'h0, 1, 0, 32'hCAFE_0001);
    dm_req = 1'b0;
    xact(1'b0, 32'h104, 3'b010, 1'b0, 32'h0, 0, 0, 32'h0010_0093);

    // 3: back-to-back DM loads with IF pending: 4 DM, IF, DM
    if_addr = 32'h108;
    dm_req = 1'b1; dm_addr = 32'h300; dm_width = 3'b100;
    xact(1'b1, 32'h300, 3'b100, 1'b0, 32'h0, 1, 0, 32'h11);
    dm_addr = 32'h304;
    xact(1'b1, 32'h304, 3'b100, 1'b0, 32'h0, 2, 0, 32'h22);
    dm_addr = 32'h308;
    xact(1'b1, 32'h308, 3'b100, 1'b0, 32'h0, 3, 0, 32'h33);
    dm_addr = 32'h30C;
    xact(1'b1, 32'h30C, 3'b100, 1'b0, 32'h0, 4, 0, 32'h44);
    dm_addr = 32'h310;
    xact(1'b0, 32'h108, 3'b010, 1'b0, 32'h0, 0, 0, 32'h55);
    if_addr = 32'h10C;
    xact(1'b1, 32'h310, 3'b100, 1'b0, 32'h0, 1, 0, 32'h66);
    dm_req = 1'b0; if_req = 1'b0;

    // 5: store with fields held for two wait cycles
    nclk();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF;
    dm_width = 3'b010;
    xact(1'b1, 32'h80, 3'b010, 1'b1, 32'hDEAD_BEEF, 0, 2, 32'h0);
    dm_req = 1'b0; dm_we = 1'b0;

    // 4: flush during BUSY_IF; completion is swallowed
    nclk();
    if_req = 1'b1; if_addr = 32'h140;
    nclk(); #1;
    chk("fl_state", 32'(dbg_state), 32'(S_BUSY_IF));
    if_flush = 1'b1;
    nclk();
    if_flush = 1'b0;
    #1;
    chk1("fl_hold1", mem_req, 1'b1);
    nclk(); #1;
    chk1("fl_hold2", mem_req, 1'b1);
    nclk(); #1;
    chk1("fl_hold3", mem_req, 1'b1);
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    nclk();
    mem_ready = 1'b0; if_addr = 32'h200;
    #1;
    chk("fl_resp_state", 32'(dbg_state), 32'(S_RESP_IF));
    chk1("fl_if_valid", if_valid, 1'b0);
    chk1("fl_if_stall", if_stall, 1'b1);
    nclk(); #1;
    chk1("fl_idle_valid", if_valid, 1'b0);
    xact(1'b0, 32'h200, 3'b010, 1'b0, 32'h0, 0, 0, 32'h0000_0200);
    if_req = 1'b0;

    // Flush in the RESP_IF cycle itself suppresses that pulse
    nclk();
    if_req = 1'b1; if_addr = 32'h400;
    nclk(); #1;
    chk("rf_state", 32'(dbg_state), 32'(S_BUSY_IF));
    mem_ready = 1'b1; mem_rdata = 32'h77;
    nclk();
    mem_ready = 1'b0; if_flush = 1'b1;
    #1;
    chk("rf_resp_state", 32'(dbg_state), 32'(S_RESP_IF));
    chk1("rf_if_valid", if_valid, 1'b0);
    if_flush = 1'b0; if_req = 1'b0;
    nclk(); #1;
    chk("rf_idle", 32'(dbg_state), 32'(S_IDLE));
    if_req = 1'b1; if_addr = 32'h404;
    xact(1'b0, 32'h404, 3'b010, 1'b0, 32'h0, 0, 0, 32'h88);
    if_req = 1'b0;

    // 6: timeout after 8 BUSY cycles, response carries zero
    nclk();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; dm_width = 3'b010;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      nclk(); #1;
      chk1("to_mem_req", mem_req, 1'b1);
      chk1("to_no_err", bus_err, 1'b0);
    end
    nclk(); #1;
    chk1("to_abort_req", mem_req, 1'b0);
    chk1("to_bus_err", bus_err, 1'b1);
    chk("to_abort_state", 32'(dbg_state), 32'(S_BUSY_DM));
    nclk(); #1;
    chk1("to_dm_valid", dm_valid, 1'b1);
    chk("to_dm_rdata", dm_rdata, 32'h0);
    chk1("to_err_cleared", bus_err, 1'b0);
    dm_req = 1'b0;
    nclk(); #1;
    chk("to_idle", 32'(dbg_state), 32'(S_IDLE));
    chk1("to_idle_valid", dm_valid, 1'b0);

    // Reset during BUSY: mem_req drops next cycle, no valid pulse
    dm_req = 1'b1; dm_addr = 32'h600;
    nclk(); #1;
    chk1("mr_busy_req", mem_req, 1'b1);
    rst_n = 1'b0;
    nclk(); #1;
    chk1("mr_mem_req", mem_req, 1'b0);
    chk1("mr_dm_valid", dm_valid, 1'b0);
    chk("mr_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1; dm_req = 1'b0; mem_ready = 1'b1;
    nclk(); #1;
    chk1("mr_no_valid", dm_valid, 1'b0);
    chk1("mr_ready_ignored", mem_req, 1'b0);
    chk("mr_idle", 32'(dbg_state), 32'(S_IDLE));
    mem_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
